i2c_req_arbiter: RTL

- Shares the single I2C_Controller (24-bit {slave, sub-addr, data} word, GO/END/ACK handshake) between N requesters.
- Typical requesters: the codec power-up LUT sequencer, a runtime headphone-volume control and a video-decoder config port.
- Grants round-robin, launches one transfer at a time, retries on NACK, enforces a timeout, and returns per-requester done/status.
- Sits between the requesters and the controller instance, in the iCLK domain.

---
 rtl/i2c_req_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C_Controller between N requesters.
// Each winner's 24-bit word is latched at grant. The arbiter runs one GO/END/ACK
// handshake at a time, retries NACKed transfers after an idle gap, and times out
// stalled handshakes. Completion is reported as a per-requester done pulse plus a status.
//
// Ports:
//   iCLK, iRST       clock, synchronous active-high reset
//   iREQ[N]          per-requester request level
//   iDATA[24*N]      per-requester word, slice i = [24i+23:24i]
//   oGNT[N]          one-hot grant, high while requester i owns the controller
//   oDONE[N]         one-cycle completion pulse for the winner
//   oSTAT[2]         last completion status: 00 ok, 01 NACK after retries, 10 timeout
//   oBUSY            high whenever the FSM is not idle
//   oI2C_GO          controller GO
//   oI2C_DATA[24]    controller word
//   iI2C_END         controller END (asynchronous)
//   iI2C_ACK         controller ACK, 1 = NACK (asynchronous)
module i2c_req_arbiter #(
  parameter int unsigned N           = 3,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 1024,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [N-1:0]    iREQ,
  input  logic [24*N-1:0] iDATA,
  output logic [N-1:0]    oGNT,
  output logic [N-1:0]    oDONE,
  output logic [1:0]      oSTAT,
  output logic            oBUSY,
  output logic            oI2C_GO,
  output logic [23:0]     oI2C_DATA,
  input  logic            iI2C_END,
  input  logic            iI2C_ACK
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatNack    = 2'b01;
  localparam logic [1:0] StatTimeout = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWaitEnd, StRelease, StGap, StReleaseTo, StDone
  } state_e;

  state_e          state_q, state_d;
  logic            end_meta_q, end_s_q, ack_meta_q, ack_s_q;
  logic            ack_cap_q, ack_cap_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [23:0]     data_q, data_d;
  logic [3:0]      retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            go_q, go_d;
  logic [23:0]     i2c_data_q, i2c_data_d;
  logic [1:0]      stat_q, stat_d;

  logic            req_any;
  logic [IW-1:0]   req_idx, scan_idx;
  logic            timer_hit, gap_hit, retry_left;

  // Hit is flagged in the last allowed cycle so GO stays high exactly TIMEOUT_CYC cycles.
  assign timer_hit  = (32'(timer_q) + 32'd1) >= TIMEOUT_CYC;
  assign gap_hit    = (32'(gap_q) + 32'd1) >= RETRY_GAP;
  assign retry_left = 32'(retry_q) < MAX_RETRY;

  // First set request scanning upward from the pointer, with wrap.
  always_comb begin
    req_any  = 1'b0;
    req_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = IW'((32'(ptr_q) + k) % N);
      if (!req_any && iREQ[scan_idx]) begin
        req_any = 1'b1;
        req_idx = scan_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic. END takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (req_any) state_d = StLaunch;
      StLaunch:    state_d = StWaitEnd;
      StWaitEnd: begin
        if (end_s_q)        state_d = StRelease;
        else if (timer_hit) state_d = StReleaseTo;
      end
      StRelease: begin
        if (!end_s_q)       state_d = (ack_cap_q && retry_left) ? StGap : StDone;
        else if (timer_hit) state_d = StDone;
      end
      StGap:       if (gap_hit) state_d = StLaunch;
      StReleaseTo: if (!end_s_q || timer_hit) state_d = StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    ack_cap_d  = ack_cap_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    retry_d    = retry_q;
    gnt_d      = gnt_q;
    go_d       = go_q;
    i2c_data_d = i2c_data_q;
    stat_d     = stat_q;
    // Timer restarts on every state change and saturates rather than wrapping.
    if (state_d != state_q)                timer_d = '0;
    else if (timer_q == TW'(TIMEOUT_CYC))  timer_d = timer_q;
    else                                   timer_d = timer_q + TW'(1);
    gap_d = (state_q == StGap && !gap_hit) ? gap_q + GW'(1) : '0;

    case (state_q)
      StIdle: begin
        if (req_any) begin
          winner_d = req_idx;
          retry_d  = '0;
          for (int unsigned i = 0; i < N; i++) begin
            gnt_d[i] = (IW'(i) == req_idx);
            if (IW'(i) == req_idx) data_d = iDATA[24*i +: 24];
          end
        end
      end
      StLaunch: begin
        go_d       = 1'b1;
        i2c_data_d = data_q;
      end
      StWaitEnd: begin
        if (end_s_q) begin
          ack_cap_d = ack_s_q;
          go_d      = 1'b0;
        end else if (timer_hit) begin
          go_d = 1'b0;
        end
      end
      StRelease: begin
        if (!end_s_q) begin
          if (!ack_cap_q)      stat_d  = StatOk;
          else if (retry_left) retry_d = retry_q + 4'd1;
          else                 stat_d  = StatNack;
        end else if (timer_hit) begin
          stat_d = StatTimeout;
        end
      end
      StReleaseTo: if (!end_s_q || timer_hit) stat_d = StatTimeout;
      StDone: begin
        gnt_d = '0;
        ptr_d = (winner_q == IW'(N - 1)) ? '0 : winner_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      end_meta_q <= 1'b0;
      end_s_q    <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      ack_cap_q  <= 1'b0;
      winner_q   <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      gnt_q      <= '0;
      go_q       <= 1'b0;
      i2c_data_q <= '0;
      stat_q     <= StatOk;
    end else begin
      end_meta_q <= iI2C_END;
      end_s_q    <= end_meta_q;
      ack_meta_q <= iI2C_ACK;
      ack_s_q    <= ack_meta_q;
      ack_cap_q  <= ack_cap_d;
      winner_q   <= winner_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      gnt_q      <= gnt_d;
      go_q       <= go_d;
      i2c_data_q <= i2c_data_d;
      stat_q     <= stat_d;
    end
  end

  // Outputs.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      oDONE[i] = (state_q == StDone) && (winner_q == IW'(i));
    end
    oBUSY     = (state_q != StIdle);
    oGNT      = gnt_q;
    oSTAT     = stat_q;
    oI2C_GO   = go_q;
    oI2C_DATA = i2c_data_q;
  end

endmodule
